cmp_window_stats: RTL and testbench



---
 rtl/cmp_window_stats_if.sv | 32 +++
 rtl/cmp_window_stats.sv | 74 +++++++
 tb/tb_cmp_window_stats.sv | 139 +++++++++++++
 3 files changed

// File: rtl/cmp_window_stats_if.sv
// cmp_window_stats_if: sample-input and window-result handshake bundle for cmp_window_stats
interface cmp_window_stats_if #(
    parameter int N      = 8,
    parameter int WINDOW = 16
);
    localparam int CW = $clog2(WINDOW + 1);

    logic          in_valid;
    logic          in_ready;
    logic [N-1:0]  a;
    logic [N-1:0]  b;
    logic          lesser;
    logic          equal;
    logic          greater;
    logic          out_valid;
    logic          out_ready;
    logic [CW-1:0] cnt_lt;
    logic [CW-1:0] cnt_eq;
    logic [CW-1:0] cnt_gt;
    logic [N-1:0]  max_val;
    logic          flag_err;

    modport master (
        output in_valid, a, b, lesser, equal, greater, out_ready,
        input  in_ready, out_valid, cnt_lt, cnt_eq, cnt_gt, max_val, flag_err
    );

    modport slave (
        input  in_valid, a, b, lesser, equal, greater, out_ready,
        output in_ready, out_valid, cnt_lt, cnt_eq, cnt_gt, max_val, flag_err
    );
endinterface

// File: rtl/cmp_window_stats.sv
// cmp_window_stats: per-window outcome counts and winning-operand maximum over comparator results
module cmp_window_stats #(
    parameter int N      = 8,
    parameter int WINDOW = 16
) (
    input logic               clk,
    input logic               rst_n,
    cmp_window_stats_if.slave bus
);
    localparam int CW = $clog2(WINDOW + 1);

    typedef enum logic {COLLECT, REPORT} state_t;

    state_t        r_state;
    logic [CW-1:0] r_samples;
    logic [CW-1:0] r_cnt_lt;
    logic [CW-1:0] r_cnt_eq;
    logic [CW-1:0] r_cnt_gt;
    logic [N-1:0]  r_max;
    logic          r_err;

    logic          w_accept;
    logic          w_onehot;
    logic          w_last;
    logic [N-1:0]  w_winner;

    // odd parity excluding the all-three case leaves exactly one flag set
    assign w_accept = bus.in_valid & (r_state == COLLECT);
    assign w_onehot = (bus.lesser ^ bus.equal ^ bus.greater) & ~(bus.lesser & bus.equal & bus.greater);
    assign w_winner = bus.greater ? bus.a : bus.b;
    assign w_last   = r_samples == CW'(WINDOW - 1);

    assign bus.in_ready  = r_state == COLLECT;
    assign bus.out_valid = r_state == REPORT;
    assign bus.cnt_lt    = r_cnt_lt;
    assign bus.cnt_eq    = r_cnt_eq;
    assign bus.cnt_gt    = r_cnt_gt;
    assign bus.max_val   = r_max;
    assign bus.flag_err  = r_err;

    // window FSM: accumulate accepted samples, hold the result until downstream takes it
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= COLLECT;
            r_samples <= '0;
            r_cnt_lt  <= '0;
            r_cnt_eq  <= '0;
            r_cnt_gt  <= '0;
            r_max     <= '0;
            r_err     <= 1'b0;
        end else if (r_state == COLLECT) begin
            if (w_accept) begin
                r_samples <= r_samples + CW'(1);
                if (w_onehot) begin
                    if (bus.lesser)  r_cnt_lt <= r_cnt_lt + CW'(1);
                    if (bus.equal)   r_cnt_eq <= r_cnt_eq + CW'(1);
                    if (bus.greater) r_cnt_gt <= r_cnt_gt + CW'(1);
                    if (w_winner > r_max) r_max <= w_winner;
                end else begin
                    r_err <= 1'b1;
                end
                if (w_last) r_state <= REPORT;
            end
        end else if (bus.out_ready) begin
            r_state   <= COLLECT;
            r_samples <= '0;
            r_cnt_lt  <= '0;
            r_cnt_eq  <= '0;
            r_cnt_gt  <= '0;
            r_max     <= '0;
            r_err     <= 1'b0;
        end
    end
endmodule

// File: tb/tb_cmp_window_stats.sv
// tb_cmp_window_stats: table-driven windows plus backpressure and reset sequences
module tb_cmp_window_stats;
    localparam int N = 8;
    localparam int WINDOW = 4;
    localparam logic [2:0] LT = 3'b100;
    localparam logic [2:0] EQ = 3'b010;
    localparam logic [2:0] GT = 3'b001;

    typedef struct packed {
        logic [3:0][7:0] a;
        logic [3:0][7:0] b;
        logic [3:0][2:0] f;
        logic            sparse;
        logic [2:0]      lt;
        logic [2:0]      eq;
        logic [2:0]      gt;
        logic [7:0]      mx;
        logic            err;
    } vec_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int checks = 0;
    int errors = 0;
    vec_t tbl [6];

    cmp_window_stats_if #(.N(N), .WINDOW(WINDOW)) bus ();

    cmp_window_stats #(.N(N), .WINDOW(WINDOW)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
        end
    endtask

    task automatic drive(input logic v, input logic [7:0] a, input logic [7:0] b, input logic [2:0] f);
        bus.in_valid = v;
        bus.a        = a;
        bus.b        = b;
        bus.lesser   = f[2];
        bus.equal    = f[1];
        bus.greater  = f[0];
    endtask

    task automatic chk_result(input string tag, input logic v, input logic rdy, input logic [2:0] lt,
                              input logic [2:0] eq, input logic [2:0] gt, input logic [7:0] mx, input logic err);
        chk({tag, "_out_valid"}, 32'(bus.out_valid), 32'(v));
        chk({tag, "_in_ready"}, 32'(bus.in_ready), 32'(rdy));
        chk({tag, "_cnt_lt"}, 32'(bus.cnt_lt), 32'(lt));
        chk({tag, "_cnt_eq"}, 32'(bus.cnt_eq), 32'(eq));
        chk({tag, "_cnt_gt"}, 32'(bus.cnt_gt), 32'(gt));
        chk({tag, "_max_val"}, 32'(bus.max_val), 32'(mx));
        chk({tag, "_flag_err"}, 32'(bus.flag_err), 32'(err));
    endtask

    task automatic consume(input string tag);
        @(negedge clk);
        bus.out_ready = 1'b1;
        @(negedge clk);
        bus.out_ready = 1'b0;
        chk_result({tag, "_clr"}, 1'b0, 1'b1, 3'd0, 3'd0, 3'd0, 8'd0, 1'b0);
    endtask

    task automatic run_window(input string tag, input vec_t v, input bit do_consume);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            if (v.sparse && i > 0) begin
                drive(1'b0, 8'd0, 8'd0, 3'b000);
                @(negedge clk);
            end
            if (i == 0) chk({tag, "_ready_start"}, 32'(bus.in_ready), 32'd1);
            if (i == 3) chk({tag, "_not_early"}, 32'(bus.out_valid), 32'd0);
            drive(1'b1, v.a[i], v.b[i], v.f[i]);
        end
        @(negedge clk);
        drive(1'b0, 8'd0, 8'd0, 3'b000);
        chk_result(tag, 1'b1, 1'b0, v.lt, v.eq, v.gt, v.mx, v.err);
        if (do_consume) consume(tag);
    endtask

    initial begin
        tbl[0] = '{a:{8'd7, 8'd50, 8'd30, 8'd10}, b:{8'd9, 8'd5, 8'd30, 8'd20}, f:{LT, GT, EQ, LT},
                   sparse:1'b0, lt:3'd2, eq:3'd1, gt:3'd1, mx:8'd50, err:1'b0};
        tbl[1] = '{a:{8'd60, 8'd40, 8'd200, 8'd10}, b:{8'd3, 8'd40, 8'd1, 8'd20}, f:{GT, EQ, 3'b101, LT},
                   sparse:1'b0, lt:3'd1, eq:3'd1, gt:3'd1, mx:8'd60, err:1'b1};
        tbl[2] = '{a:{8'd1, 8'd0, 8'd0, 8'd255}, b:{8'd2, 8'd0, 8'd255, 8'd0}, f:{LT, EQ, LT, GT},
                   sparse:1'b0, lt:3'd2, eq:3'd1, gt:3'd1, mx:8'd255, err:1'b0};
        tbl[3] = '{a:{8'd2, 8'd8, 8'd9, 8'd3}, b:{8'd2, 8'd1, 8'd9, 8'd4}, f:{3'b000, GT, EQ, LT},
                   sparse:1'b1, lt:3'd1, eq:3'd1, gt:3'd1, mx:8'd9, err:1'b1};
        tbl[4] = '{a:{8'd99, 8'd0, 8'd7, 8'd100}, b:{8'd1, 8'd0, 8'd7, 8'd100}, f:{GT, EQ, 3'b111, EQ},
                   sparse:1'b0, lt:3'd0, eq:3'd2, gt:3'd1, mx:8'd100, err:1'b1};
        tbl[5] = '{a:{8'd3, 8'd2, 8'd6, 8'd5}, b:{8'd3, 8'd1, 8'd6, 8'd250}, f:{EQ, GT, EQ, LT},
                   sparse:1'b0, lt:3'd1, eq:3'd2, gt:3'd1, mx:8'd250, err:1'b0};
        drive(1'b0, 8'd0, 8'd0, 3'b000);
        bus.out_ready = 1'b0;
        repeat (2) @(negedge clk);
        chk_result("reset", 1'b0, 1'b1, 3'd0, 3'd0, 3'd0, 8'd0, 1'b0);
        rst_n = 1'b1;
        for (int k = 0; k < 6; k++) run_window($sformatf("win%0d", k), tbl[k], 1'b1);
        run_window("bp", tbl[0], 1'b0);
        for (int c = 0; c < 5; c++) begin
            drive(1'b1, 8'd250, 8'd1, GT);
            @(negedge clk);
            chk_result($sformatf("bp_hold%0d", c), 1'b1, 1'b0, 3'd2, 3'd1, 3'd1, 8'd50, 1'b0);
        end
        drive(1'b0, 8'd0, 8'd0, 3'b000);
        consume("bp");
        run_window("after_bp", tbl[2], 1'b1);
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            drive(1'b1, 8'd250, 8'd1, GT);
        end
        @(negedge clk);
        drive(1'b0, 8'd0, 8'd0, 3'b000);
        chk("mid_partial_gt", 32'(bus.cnt_gt), 32'd2);
        #2 rst_n = 1'b0;
        #1 chk_result("mid_rst", 1'b0, 1'b1, 3'd0, 3'd0, 3'd0, 8'd0, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;
        run_window("after_mid_rst", tbl[5], 1'b1);
        run_window("rpt", tbl[1], 1'b0);
        #2 rst_n = 1'b0;
        #1 chk_result("rpt_rst", 1'b0, 1'b1, 3'd0, 3'd0, 3'd0, 8'd0, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;
        run_window("after_rpt_rst", tbl[4], 1'b1);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
